// File: rtl/polar_sc_dec32.sv
`default_nettype none
// ============================================================================
// Module   : polar_sc_dec32
// Brief    : Successive-cancellation decoder for the N=32 polar code with
//            min-sum f, saturating g, 1 tree-node activation per cycle.
//            Optional macro POLAR_SC_CW_OUT_EN adds the re-encoded codeword port.
// Revision : 1.0 - initial release
// ============================================================================
module polar_sc_dec32 #(
    parameter int          LLR_W       = 6,
    parameter logic [31:0] FROZEN_MASK = 32'hFEE8E880
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*LLR_W-1:0] llr_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         dout,
`ifdef POLAR_SC_CW_OUT_EN
    output logic [31:0]         cw_out,
`endif
    output logic                busy
);

    localparam int IW = LLR_W + 2;
    localparam logic signed [IW-1:0] LLR_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] LLR_MIN = {1'b1, {(IW-2){1'b0}}, 1'b1};
    localparam logic signed [IW-1:0] RAW_MIN = {3'b111, {(LLR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [4:0]  leaf_q, leaf_d;
    logic [31:0] dec_q, dec_d;
    logic [31:0] dout_q, dout_d;
`ifdef POLAR_SC_CW_OUT_EN
    logic [31:0] cw_q, cw_d;
`endif

    // Per-stage LLR memories; stage s holds the 2^s LLRs of the active node.
    logic signed [IW-1:0] a5_q [32];
    logic signed [IW-1:0] a4_q [16];
    logic signed [IW-1:0] a3_q [8];
    logic signed [IW-1:0] a2_q [4];
    logic signed [IW-1:0] a1_q [2];

    logic signed [IW-1:0] w_par [32];
    logic signed [IW-1:0] w_res [16];
    logic [15:0]          w_beta_l;
    logic [4:0]           w_size;
    logic [4:0]           w_sib;
    logic [4:0]           w_idx;
    logic                 w_is_g;
    logic                 w_leaf_bit;
    logic                 w_accept;
    logic                 w_step;

    function automatic logic signed [IW-1:0] sext_in(input logic [LLR_W-1:0] raw);
        return {{2{raw[LLR_W-1]}}, raw};
    endfunction

    function automatic logic signed [IW-1:0] fix_min(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] r;
        r = v;
        if (v == RAW_MIN) r = v + {{(IW-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // Operands are always inside the symmetric range, so negation cannot overflow.
    function automatic logic signed [IW-1:0] f_op(input logic signed [IW-1:0] a,
                                                  input logic signed [IW-1:0] b);
        logic signed [IW-1:0] ma, mb, mn;
        ma = a[IW-1] ? -a : a;
        mb = b[IW-1] ? -b : b;
        mn = (ma < mb) ? ma : mb;
        return (a[IW-1] ^ b[IW-1]) ? -mn : mn;
    endfunction

    function automatic logic signed [IW-1:0] g_op(input logic signed [IW-1:0] a,
                                                  input logic signed [IW-1:0] b,
                                                  input logic beta);
        logic signed [IW:0] s;
        logic signed [IW-1:0] r;
        s = beta ? ((IW+1)'(b) - (IW+1)'(a)) : ((IW+1)'(b) + (IW+1)'(a));
        if (s > (IW+1)'(LLR_MAX))      r = LLR_MAX;
        else if (s < (IW+1)'(LLR_MIN)) r = LLR_MIN;
        else                           r = s[IW-1:0];
        return r;
    endfunction

    function automatic logic [2:0] ctz5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd4;
        for (int b = 4; b >= 0; b--) begin
            if (v[b]) n = 3'(b);
        end
        return n;
    endfunction

`ifdef POLAR_SC_CW_OUT_EN
    // x[k] = XOR of u[j] over every j whose set bits are a subset of k's.
    function automatic logic [31:0] encode(input logic [31:0] u);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 32; j++) begin
                if ((j & k) == j) x[k] = x[k] ^ u[j];
            end
        end
        return x;
    endfunction
`endif

    assign w_accept = (state_q == S_IDLE) && in_valid;
    assign w_step   = (state_q == S_DECODE) && !load_q;

    // Datapath: parent selection, left-sibling partial sums, f/g array.
    always_comb begin
        w_size = 5'd1 << lvl_q;
        w_is_g = leaf_q[lvl_q];
        w_sib  = leaf_q - w_size;
        w_idx  = '0;

        for (int j = 0; j < 32; j++) w_par[j] = '0;
        case (lvl_q)
            3'd4:    for (int j = 0; j < 32; j++) w_par[j] = a5_q[j];
            3'd3:    for (int j = 0; j < 16; j++) w_par[j] = a4_q[j];
            3'd2:    for (int j = 0; j < 8; j++)  w_par[j] = a3_q[j];
            3'd1:    for (int j = 0; j < 4; j++)  w_par[j] = a2_q[j];
            default: for (int j = 0; j < 2; j++)  w_par[j] = a1_q[j];
        endcase

        // Left-sibling beta is the polar encoding of its already-decided bits.
        w_beta_l = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if ((5'(j) < w_size) && ((j & i) == i))
                    w_beta_l[i] = w_beta_l[i] ^ dec_q[w_sib + 5'(j)];
            end
        end

        for (int i = 0; i < 16; i++) begin
            w_idx    = 5'(i) + w_size;
            w_res[i] = w_is_g ? g_op(w_par[i], w_par[w_idx], w_beta_l[i])
                              : f_op(w_par[i], w_par[w_idx]);
        end

        w_leaf_bit = !FROZEN_MASK[5'd31 - leaf_q] && w_res[0][IW-1];
    end

    // FSM next-state and outputs.
    always_comb begin
        state_d   = state_q;
        load_d    = 1'b0;
        lvl_d     = lvl_q;
        leaf_d    = leaf_q;
        dec_d     = dec_q;
        dout_d    = dout_q;
`ifdef POLAR_SC_CW_OUT_EN
        cw_d      = cw_q;
`endif
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_DECODE) || (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DECODE;
                    load_d  = 1'b1;
                    lvl_d   = 3'd4;
                    leaf_d  = 5'd0;
                    dec_d   = '0;
                end
            end
            S_DECODE: begin
                if (!load_q) begin
                    if (lvl_q != 3'd0) begin
                        lvl_d = lvl_q - 3'd1;
                    end else begin
                        dec_d[leaf_q] = w_leaf_bit;
                        if (leaf_q == 5'd31) begin
                            state_d = S_DONE;
                            for (int i = 0; i < 32; i++) dout_d[i] = dec_d[31-i];
`ifdef POLAR_SC_CW_OUT_EN
                            cw_d = encode(dout_d);
`endif
                        end else begin
                            // Climb to the parent whose right child holds the next leaf.
                            leaf_d = leaf_q + 5'd1;
                            lvl_d  = ctz5(leaf_q + 5'd1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            lvl_q   <= 3'd0;
            leaf_q  <= 5'd0;
            dec_q   <= '0;
            dout_q  <= '0;
`ifdef POLAR_SC_CW_OUT_EN
            cw_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            lvl_q   <= lvl_d;
            leaf_q  <= leaf_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
`ifdef POLAR_SC_CW_OUT_EN
            cw_q    <= cw_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) a5_q[k] <= '0;
            for (int k = 0; k < 16; k++) a4_q[k] <= '0;
            for (int k = 0; k < 8; k++)  a3_q[k] <= '0;
            for (int k = 0; k < 4; k++)  a2_q[k] <= '0;
            for (int k = 0; k < 2; k++)  a1_q[k] <= '0;
        end else begin
            // Index reversal on capture; the load cycle then folds -2^(W-1) inward.
            if (w_accept) begin
                for (int k = 0; k < 32; k++)
                    a5_q[k] <= sext_in(llr_in[(31-k)*LLR_W +: LLR_W]);
            end else if (state_q == S_DECODE && load_q) begin
                for (int k = 0; k < 32; k++) a5_q[k] <= fix_min(a5_q[k]);
            end
            if (w_step) begin
                case (lvl_q)
                    3'd4:    for (int i = 0; i < 16; i++) a4_q[i] <= w_res[i];
                    3'd3:    for (int i = 0; i < 8; i++)  a3_q[i] <= w_res[i];
                    3'd2:    for (int i = 0; i < 4; i++)  a2_q[i] <= w_res[i];
                    3'd1:    for (int i = 0; i < 2; i++)  a1_q[i] <= w_res[i];
                    default: ;
                endcase
            end
        end
    end

    assign dout = dout_q;
`ifdef POLAR_SC_CW_OUT_EN
    assign cw_out = cw_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_polar_sc_dec32.sv
`default_nettype none
// ============================================================================
// Module   : tb_polar_sc_dec32
// Brief    : Directed, table-driven bench for polar_sc_dec32 (N=32, LLR_W=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_polar_sc_dec32;

    localparam int          W    = 6;
    localparam logic [31:0] INFO = 32'h0117177F;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b1;
    logic [32*W-1:0] llr_in    = '0;
    logic            in_ready;
    logic            out_valid;
    logic            busy;
    logic [31:0]     dout;
`ifdef POLAR_SC_CW_OUT_EN
    logic [31:0]     cw_out;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    polar_sc_dec32 #(.LLR_W(W), .FROZEN_MASK(32'hFEE8E880)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .llr_in    (llr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
`ifdef POLAR_SC_CW_OUT_EN
        .cw_out    (cw_out),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [32*W-1:0] llr;
        logic [31:0]     u;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] encode(input logic [31:0] u);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 32; j++)
                if ((j & k) == j) x[k] = x[k] ^ u[j];
        return x;
    endfunction

    function automatic logic [32*W-1:0] mk(input logic [31:0] u, input int pos, input int neg);
        logic [31:0]     x;
        logic [32*W-1:0] v;
        x = encode(u);
        for (int k = 0; k < 32; k++) v[k*W +: W] = W'(x[k] ? neg : pos);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one block; returns with the DUT in DONE (or after the bound expired).
    task automatic start_and_wait(input string name, input logic [32*W-1:0] llr, input logic [31:0] u_exp);
        int cyc;
        check({name, " in_ready before"}, 32'(in_ready), 32'd1);
        llr_in   = llr;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({name, " busy c1"}, {31'b0, busy, in_ready}, 32'd2);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd64);
        check({name, " dout"}, dout, u_exp);
`ifdef POLAR_SC_CW_OUT_EN
        check({name, " cw_out"}, cw_out, encode(u_exp));
`endif
    endtask

    task automatic run_block(input string name, input logic [32*W-1:0] llr, input logic [31:0] u_exp);
        start_and_wait(name, llr, u_exp);
        step();
        check({name, " back to idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [32*W-1:0] noisy;
        logic [31:0]     held;
        logic            seen;

        vecs[0] = '{mk(32'h0, 31, -31), 32'h0};
        vecs[1] = '{mk(INFO, 31, -31), INFO};
        // x[31] of this codeword is 0, so -1 is a weak wrong-sign sample. The
        // -32 goes on bit 7, the lowest codeword bit above 5 that is a 1 here.
        noisy = mk(INFO, 31, -31);
        noisy[31*W +: W] = W'(-1);
        noisy[7*W +: W]  = W'(-32);
        vecs[2] = '{noisy, INFO};
        vecs[3] = '{'0, 32'h0};
        vecs[4] = '{mk(32'h1, 31, -32), 32'h1};
        vecs[5] = '{mk(32'h01000000, 5, -5), 32'h01000000};
        vecs[6] = '{mk(32'h00012345 & INFO, 3, -3), 32'h00012345 & INFO};

        repeat (3) @(posedge clk);
        #1;
        check("reset state", {29'b0, in_ready, out_valid, busy}, 32'd4);
        check("reset dout", dout, 32'h0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++)
            run_block($sformatf("vec%0d", v), vecs[v].llr, vecs[v].u);

        // Backpressure with an extra input pulse that must be dropped.
        out_ready = 1'b0;
        start_and_wait("bp", vecs[1].llr, INFO);
        held = dout;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                llr_in   = vecs[0].llr;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            check($sformatf("bp hold %0d", c), {dout[31:3], out_valid, in_ready, busy},
                  {held[31:3], 1'b1, 1'b0, 1'b1});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp release", {29'b0, in_ready, out_valid, busy}, 32'd4);
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        check("bp dropped input", {31'b0, seen}, 32'd0);
        check("bp dout kept", dout, INFO);

        // Reset at cycle 30 of a decode.
        llr_in   = vecs[1].llr;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 30; c++) step();
        rst_n = 1'b0;
        #1;
        check("midrst state", {29'b0, in_ready, out_valid, busy}, 32'd4);
        check("midrst dout", dout, 32'h0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("midrst no output", {31'b0, seen}, 32'd0);
        run_block("post rst zero", vecs[0].llr, 32'h0);
        run_block("post rst info", vecs[1].llr, INFO);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
